// File: rtl/mul_pkg.sv
// Shared constants for the sequential 8x8 shift-and-add multiplier.
// Holds operand/counter widths and the FSM state encodings.
package mul_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier_8bit_adder.sv
// Adder8bit: combinational 8-bit adder with carry-in and carry-out.
// Ports: a, b (8-bit addends), c (carry-in) -> s (8-bit sum), co (carry-out).
module Adder8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c,
    output logic [7:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {8'b0, c};

endmodule

// File: rtl/seq_multiplier_8bit.sv
// Unsigned 8x8 -> 16-bit shift-and-add multiplier, one partial product per clock.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done (1-cycle pulse),
// product (held from done until the next accepted start).
// Optional macro EARLY_TERM_EN: a zero operand skips CALC and reports 0 in one clock.
module seq_multiplier_8bit
    import mul_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   a,
    input  logic [7:0]   b,
    output logic         busy,
    output logic         done,
    output logic [15:0]  product
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_p;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_product;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_last;
    logic             w_can_accept;

    assign w_addend     = r_q[0] ? r_m : '0;
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DONE);

    Adder8bit u_add (
        .a  (r_p),
        .b  (w_addend),
        .c  (1'b0),
        .s  (w_sum),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && w_can_accept) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_p   <= '0;
                        r_cnt <= '0;
`ifdef EARLY_TERM_EN
                        if (a == '0 || b == '0) begin
                            r_state   <= ST_DONE;
                            r_product <= '0;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Carry-out becomes the new MSB of P, so the 9th bit is kept
                    r_p   <= {w_co, w_sum[WIDTH-1:1]};
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_co, w_sum, r_q[WIDTH-1:1]};
                        r_state   <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == ST_CALC);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule
